ip_header_tx: RTL

// - Transmit-side counterpart of the IPv4 header checker. Serialises a 20-byte IPv4/UDP header
//   (no options), MSB first, onto an 8-bit byte stream.
// - Sits between the Ethernet header TX (which precedes it) and the UDP header TX (which follows).
// - Fields: version/IHL 0x45, TOS 0x00, total length, identification, flags/offset 0x0000,
//   TTL, protocol 0x11, checksum, source and destination addresses.

---
 rtl/ip_pkg.sv | 20 ++
 rtl/ip_checksum.sv | 25 ++
 rtl/ip_header_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
// Shared constants, FSM state type and ones-complement helper for the IPv4 header TX path.
package ip_pkg;

  localparam logic [7:0]  IPHL        = 8'h45;
  localparam logic [7:0]  TOS         = 8'h00;
  localparam logic [15:0] FLAG_OFFSET = 16'h0000;
  localparam logic [7:0]  IP_UDP_TYPE = 8'h11;
  localparam int          IP_HDR_LEN  = 20;
  localparam int          HDR_WORDS   = IP_HDR_LEN / 2;

  typedef enum logic [1:0] {IDLE, CSUM, SEND} state_ip_tx_type;

  // 16-bit ones-complement add with end-around carry
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/ip_checksum.sv
// IPv4 header checksum accumulator: clear, add one 16-bit word per cycle, then fold and invert.
module ip_checksum
  import ip_pkg::*;
(
  input  logic        aclk,
  input  logic        clr,
  input  logic        add,
  input  logic        fin,
  input  logic [15:0] word,
  output logic [15:0] csum
);

  logic [19:0] acc_p0;

  always_ff @(posedge aclk) begin
    if (clr)
      acc_p0 <= '0;
    else if (add)
      acc_p0 <= acc_p0 + {4'b0, word};
    // fold: the first end-around add can carry at most once more, which ones_add absorbs
    if (fin)
      csum <= ~ones_add(acc_p0[15:0], {12'b0, acc_p0[19:16]});
  end

endmodule

// File: rtl/ip_header_tx.sv
// Serialises a 20-byte IPv4/UDP header MSB first onto an 8-bit ready/valid byte stream.
// Optional checksum generation is enabled by defining IP_CHECKSUM_EN.
module ip_header_tx
  import ip_pkg::*;
#(
  parameter logic [7:0]  TTL     = 8'hFF,
  parameter logic [15:0] ID_INIT = 16'h0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        header_start,
  input  logic [15:0] udp_len,
  input  logic [31:0] ip_s_addr,
  input  logic [31:0] ip_d_addr,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        ip_header_done
);

  state_ip_tx_type state, state_nxt;
  logic [4:0]   idx, idx_nxt;
  logic [7:0]   data_out_nxt;
  logic         valid_nxt, busy_nxt, done_nxt;
  logic         latch_en, id_inc;
  logic [15:0]  id_q;
  logic [15:0]  total_len_p0;
  logic [31:0]  s_addr_p0, d_addr_p0;
  logic [15:0]  csum;
  logic [159:0] hdr;

  assign hdr = {IPHL, TOS, total_len_p0, id_q, FLAG_OFFSET, TTL, IP_UDP_TYPE,
                csum, s_addr_p0, d_addr_p0};

  function automatic logic [7:0] hdr_byte(input logic [159:0] h, input logic [4:0] i);
    return h[159 - 8*int'(i) -: 8];
  endfunction

`ifdef IP_CHECKSUM_EN
  logic [3:0]   cnt, cnt_nxt;
  logic         csum_clr, csum_add, csum_fin;
  logic [159:0] hdr_sum;
  logic [15:0]  sum_word;

  // checksum field counts as zero while summing
  assign hdr_sum  = {hdr[159:80], 16'h0000, hdr[63:0]};
  assign sum_word = hdr_sum[159 - 16*int'(cnt) -: 16];

  ip_checksum u_csum (
    .aclk (aclk),
    .clr  (csum_clr),
    .add  (csum_add),
    .fin  (csum_fin),
    .word (sum_word),
    .csum (csum)
  );
`else
  assign csum = 16'h0000;
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    data_out_nxt = data_out;
    valid_nxt    = data_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    latch_en     = 1'b0;
    id_inc       = 1'b0;
`ifdef IP_CHECKSUM_EN
    cnt_nxt      = cnt;
    csum_clr     = 1'b0;
    csum_add     = 1'b0;
    csum_fin     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (header_start) begin
          latch_en = 1'b1;
          busy_nxt = 1'b1;
          idx_nxt  = '0;
`ifdef IP_CHECKSUM_EN
          cnt_nxt   = '0;
          csum_clr  = 1'b1;
          state_nxt = CSUM;
`else
          valid_nxt    = 1'b1;
          data_out_nxt = IPHL;
          state_nxt    = SEND;
`endif
        end
      end
`ifdef IP_CHECKSUM_EN
      CSUM: begin
        if (cnt < 4'(HDR_WORDS)) begin
          csum_add = 1'b1;
          cnt_nxt  = cnt + 4'd1;
        end else begin
          csum_fin     = 1'b1;
          valid_nxt    = 1'b1;
          data_out_nxt = IPHL;
          state_nxt    = SEND;
        end
      end
`endif
      SEND: begin
        if (data_ready) begin
          if (idx == 5'(IP_HDR_LEN - 1)) begin
            valid_nxt    = 1'b0;
            data_out_nxt = '0;
            done_nxt     = 1'b1;
            busy_nxt     = 1'b0;
            id_inc       = 1'b1;
            state_nxt    = IDLE;
          end else begin
            idx_nxt      = idx + 5'd1;
            data_out_nxt = hdr_byte(hdr, idx + 5'd1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= IDLE;
      idx            <= '0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      busy           <= 1'b0;
      ip_header_done <= 1'b0;
      id_q           <= ID_INIT;
`ifdef IP_CHECKSUM_EN
      cnt            <= '0;
`endif
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      data_out       <= data_out_nxt;
      data_valid     <= valid_nxt;
      busy           <= busy_nxt;
      ip_header_done <= done_nxt;
      if (id_inc)
        id_q <= id_q + 16'd1;
`ifdef IP_CHECKSUM_EN
      cnt            <= cnt_nxt;
`endif
    end
  end

  // request capture: total length wraps modulo 2^16
  always_ff @(posedge aclk) begin
    if (latch_en) begin
      total_len_p0 <= udp_len + 16'd20;
      s_addr_p0    <= ip_s_addr;
      d_addr_p0    <= ip_d_addr;
    end
  end

endmodule
